imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
Registered instruction-decode pipeline stage. Classifies each instruction's format and produces its sign-extended immediate at parametrised XLEN, with an illegal-opcode flag. Sits between fetch and the register-read/execute stage. Uses a valid/ready handshake and an optional 2-entry skid buffer for full throughput under backpressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; width of pc and imm.
SUPPORT_CSR, 1, 1: SYSTEM opcode with funct3[2]=1 yields a zero-extended uimm (CSR_UIMM format); 0: every SYSTEM instruction is I-format.
SKID, 1, 1: 2-entry skid buffer, 1 instr/cycle sustained; 0: single register, in_ready = !out_valid || out_ready.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline kill
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_instr  out  32  registered instruction
out_pc  out  XLEN  registered pc
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR_UIMM
out_illegal  out  1  unrecognised encoding

Behaviour:
- Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready. Latency 1: an accepted instruction is on out_* the next cycle.
- Decode is combinational on in_instr and is registered with it; out_* hold stable while out_valid && !out_ready.
- Formats: I = {sext instr[31:20]}; S = {sext instr[31:25], instr[11:7]}; B = {sext instr[31], instr[7], instr[30:25], instr[11:8], 0}; J = {sext instr[31], instr[19:12], instr[20], instr[30:21], 0}; U = {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64; CSR_UIMM = zero-extended instr[19:15].
- Opcode map: 0010011/0000011/1100111/0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> NONE; 1110011 -> CSR_UIMM when SUPPORT_CSR && funct3[2], else I.
- The opcodes 0011011 (I) and 0111011 (NONE) are legal only when XLEN=64.
- Illegal: instr[1:0] != 2'b11 or opcode unmapped -> out_illegal=1, out_fmt=NONE, out_imm=0. The entry still flows through the stage.
- NONE format -> out_imm=0.
- SKID=1 FSM, states EMPTY/ONE/TWO; in_ready = (state != TWO), decoded from registered state only.
  - EMPTY: in -> ONE.
  - ONE: in&&!out -> TWO (capture into skid); out&&!in -> EMPTY; in&&out -> ONE with main reloaded.
  - TWO: out -> ONE, with skid moved to main.
  - Order is strictly FIFO; no drops, no duplicates.
- flush: next state EMPTY, out_valid=0. It takes priority over a simultaneous accept, and the incoming instruction is discarded.
- Reset (any cycle, including mid-transfer): state EMPTY; out_valid=0; out_instr=0; out_pc=0; out_imm=0; out_fmt=0; out_illegal=0; in_ready=1 once state is EMPTY. The skid register clears as well.
- Payload registers load only on accept, to limit toggling; out_valid is the sole qualifier.

Decomposition:
- Package imm_pkg: opcode localparams, the FMT_* 3-bit codes, and the XLEN legality check.
- Sub-module imm_decode_comb: purely combinational (instr -> imm, fmt, illegal), parametrised by XLEN and SUPPORT_CSR.
- It is instantiated once, ahead of the main register. The skid register stores the already-decoded fields.

Test Plan:
- XLEN=32: 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
- 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, out_fmt=3. 0x00000000 -> out_illegal=1, out_imm=0, out_fmt=0.
- XLEN=64: 0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4. 0x0000001B -> legal, fmt I; same word at XLEN=32 -> out_illegal=1.
- SUPPORT_CSR=1: 0x300FD073 (csrrwi x0,mstatus,31) -> out_imm=0x1F, out_fmt=6. SUPPORT_CSR=0 -> out_imm=0x300, out_fmt=1.
- SKID=1, in_valid held for pc 0,4,8,12 with out_ready=0 for 3 cycles:
  - in_ready falls after 2 accepts.
  - After out_ready=1, outputs appear in order 0,4,8,12 at 1/cycle with no gap.
- State TWO with in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1, and the pending instruction never appears. Assert rst mid-stream -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, format codes,
// the stage occupancy states and the XLEN legality check.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] FMT_NONE     = 3'd0;
  localparam logic [2:0] FMT_I        = 3'd1;
  localparam logic [2:0] FMT_S        = 3'd2;
  localparam logic [2:0] FMT_B        = 3'd3;
  localparam logic [2:0] FMT_U        = 3'd4;
  localparam logic [2:0] FMT_J        = 3'd5;
  localparam logic [2:0] FMT_CSR_UIMM = 3'd6;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } stage_state_e;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational instruction classifier: format code, sign-extended immediate
// and illegal-encoding flag.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          SUPPORT_CSR = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  assign opcode = instr[6:0];

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: fmt = FMT_I;
        OPC_STORE:            fmt = FMT_S;
        OPC_BRANCH:           fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
        OPC_JAL:              fmt = FMT_J;
        OPC_OP:               fmt = FMT_NONE;
        // funct3[2] selects the immediate-operand CSR forms
        OPC_SYSTEM:           fmt = (SUPPORT_CSR && instr[14]) ? FMT_CSR_UIMM : FMT_I;
        OPC_OP_IMM_32: begin
          if (XLEN == 64) fmt = FMT_I;
          else            illegal = 1'b1;
        end
        OPC_OP_32: begin
          if (XLEN != 64) illegal = 1'b1;
        end
        default:              illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:        imm = XLEN'($signed(instr[31:20]));
      FMT_S:        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U:        imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J:        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21],
                                         1'b0}));
      FMT_CSR_UIMM: imm = XLEN'(instr[19:15]);
      default:      imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage with valid/ready handshake; optional 2-entry skid
// buffer holding already-decoded entries for full throughput under backpressure.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          SUPPORT_CSR = 1'b1,
  parameter bit          SKID        = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (!xlen_legal(XLEN)) begin : gen_xlen_check
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(
    .XLEN        (XLEN),
    .SUPPORT_CSR (SUPPORT_CSR)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  stage_state_e state_q, state_d;

  logic [31:0]     main_instr_q, skid_instr_q;
  logic [XLEN-1:0] main_pc_q, skid_pc_q;
  logic [XLEN-1:0] main_imm_q, skid_imm_q;
  logic [2:0]      main_fmt_q, skid_fmt_q;
  logic            main_illegal_q, skid_illegal_q;

  logic acc_in, acc_out;
  logic load_main, load_skid, skid_to_main;

  // Ready depends on registered state only when the skid buffer is present.
  assign in_ready  = SKID ? (state_q != StTwo) : ((state_q == StEmpty) || out_ready);
  assign out_valid = (state_q != StEmpty);
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (acc_in) begin
            state_d   = StOne;
            load_main = 1'b1;
          end
        end
        StOne: begin
          if (acc_in && !acc_out) begin
            state_d   = StTwo;
            load_skid = 1'b1;
          end else if (acc_out && !acc_in) begin
            state_d = StEmpty;
          end else if (acc_in && acc_out) begin
            load_main = 1'b1;
          end
        end
        StTwo: begin
          if (acc_out) begin
            state_d      = StOne;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StEmpty;
      main_instr_q   <= '0;
      main_pc_q      <= '0;
      main_imm_q     <= '0;
      main_fmt_q     <= FMT_NONE;
      main_illegal_q <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_instr_q   <= in_instr;
        main_pc_q      <= in_pc;
        main_imm_q     <= dec_imm;
        main_fmt_q     <= dec_fmt;
        main_illegal_q <= dec_illegal;
      end else if (skid_to_main) begin
        main_instr_q   <= skid_instr_q;
        main_pc_q      <= skid_pc_q;
        main_imm_q     <= skid_imm_q;
        main_fmt_q     <= skid_fmt_q;
        main_illegal_q <= skid_illegal_q;
      end
      if (load_skid) begin
        skid_instr_q   <= in_instr;
        skid_pc_q      <= in_pc;
        skid_imm_q     <= dec_imm;
        skid_fmt_q     <= dec_fmt;
        skid_illegal_q <= dec_illegal;
      end
    end
  end

  assign out_instr   = main_instr_q;
  assign out_pc      = main_pc_q;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: two configurations driven by shared stimulus,
// each tracked by a queue-based occupancy model and an arithmetic decode model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  // XLEN=32, SUPPORT_CSR=1, SKID=1
  logic        r32, v32, l32;
  logic [31:0] i32, p32, m32;
  logic [2:0]  f32;
  // XLEN=64, SUPPORT_CSR=0, SKID=0
  logic        r64, v64, l64;
  logic [31:0] i64;
  logic [63:0] p64, m64;
  logic [2:0]  f64;

  always #5 clk = ~clk;

  imm_decode_stage #(
    .XLEN        (32),
    .SUPPORT_CSR (1'b1),
    .SKID        (1'b1)
  ) dut32 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (r32),
    .in_instr    (in_instr),
    .in_pc       (in_pc[31:0]),
    .out_valid   (v32),
    .out_ready   (out_ready),
    .out_instr   (i32),
    .out_pc      (p32),
    .out_imm     (m32),
    .out_fmt     (f32),
    .out_illegal (l32)
  );

  imm_decode_stage #(
    .XLEN        (64),
    .SUPPORT_CSR (1'b0),
    .SKID        (1'b0)
  ) dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (r64),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (v64),
    .out_ready   (out_ready),
    .out_instr   (i64),
    .out_pc      (p64),
    .out_imm     (m64),
    .out_fmt     (f64),
    .out_illegal (l64)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t q32[$];
  ent_t q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates built by weighted bit sums and subtracting the sign weight.
  function automatic void ref_decode(input logic [31:0] w, input int xlen, input bit csr,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output bit ill);
    longint v;
    logic [6:0] op;
    op  = w[6:0];
    fmt = 3'd0;
    ill = 1'b0;
    v   = 0;
    if (w[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (op)
        7'h13, 7'h03, 7'h67, 7'h0F: fmt = 3'd1;
        7'h23:        fmt = 3'd2;
        7'h63:        fmt = 3'd3;
        7'h37, 7'h17: fmt = 3'd4;
        7'h6F:        fmt = 3'd5;
        7'h33:        fmt = 3'd0;
        7'h73:        fmt = (csr && w[14]) ? 3'd6 : 3'd1;
        7'h1B:        if (xlen == 64) fmt = 3'd1; else ill = 1'b1;
        7'h3B:        if (xlen != 64) ill = 1'b1;
        default:      ill = 1'b1;
      endcase
    end
    case (fmt)
      3'd1: v = longint'(w[31:20]) - (w[31] ? 4096 : 0);
      3'd2: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 4096 : 0);
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                - (w[31] ? 4096 : 0);
      3'd4: v = longint'(w[31:12]) * 4096 - (w[31] ? (longint'(1) << 32) : 0);
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                + longint'(w[30:21]) * 2 - (w[31] ? (longint'(1) << 20) : 0);
      3'd6: v = longint'(w[19:15]);
      default: v = 0;
    endcase
    imm = v;
    if (xlen == 32) imm = {32'b0, imm[31:0]};
  endfunction

  task automatic check_all();
    logic [63:0] imm;
    logic [2:0]  fmt;
    bit          ill;
    chk("valid32", v32, q32.size() > 0);
    chk("ready32", r32, q32.size() < 2);
    if (q32.size() > 0) begin
      ref_decode(q32[0].instr, 32, 1'b1, imm, fmt, ill);
      chk("instr32", i32, q32[0].instr);
      chk("pc32", p32, {32'b0, q32[0].pc[31:0]});
      chk("imm32", m32, imm);
      chk("fmt32", f32, fmt);
      chk("illegal32", l32, ill);
    end
    chk("valid64", v64, q64.size() > 0);
    chk("ready64", r64, (q64.size() == 0) || out_ready);
    if (q64.size() > 0) begin
      ref_decode(q64[0].instr, 64, 1'b0, imm, fmt, ill);
      chk("instr64", i64, q64[0].instr);
      chk("pc64", p64, q64[0].pc);
      chk("imm64", m64, imm);
      chk("fmt64", f64, fmt);
      chk("illegal64", l64, ill);
    end
  endtask

  // One clock: model transfers from current inputs, then check after the edge.
  task automatic cycle();
    bit   a32, o32, a64, o64, fl;
    ent_t e;
    a32     = in_valid && (q32.size() < 2);
    o32     = (q32.size() > 0) && out_ready;
    a64     = in_valid && ((q64.size() == 0) || out_ready);
    o64     = (q64.size() > 0) && out_ready;
    fl      = flush;
    e.instr = in_instr;
    e.pc    = in_pc;
    @(posedge clk);
    #1;
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (o32) void'(q32.pop_front());
      if (a32) q32.push_back(e);
      if (o64) void'(q64.pop_front());
      if (a64) q64.push_back(e);
    end
    check_all();
  endtask

  task automatic send(input logic [31:0] w);
    in_valid  = 1'b1;
    in_instr  = w;
    in_pc     = {$urandom, $urandom};
    out_ready = 1'b1;
    flush     = 1'b0;
    cycle();
    in_valid  = 1'b0;
  endtask

  logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17,
                           7'h6F, 7'h33, 7'h73, 7'h1B, 7'h3B};

  initial begin
    logic [31:0] r;
    logic [63:0] next_pc;
    int          k;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    @(posedge clk);
    #1;
    chk("rst_valid32", v32, 0);
    chk("rst_ready32", r32, 1);
    chk("rst_imm32", m32, 0);
    chk("rst_valid64", v64, 0);
    chk("rst_pc64", p64, 0);
    rst = 1'b0;

    // Directed decode values
    send(32'hFFF00093);
    chk("addi_imm32", m32, 64'hFFFF_FFFF);
    chk("addi_fmt32", f32, 1);
    chk("addi_imm64", m64, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFE000EE3);
    chk("beq_imm32", m32, 64'hFFFF_FFFC);
    chk("beq_fmt32", f32, 3);
    send(32'h0000_0000);
    chk("zero_ill32", l32, 1);
    chk("zero_imm32", m32, 0);
    chk("zero_fmt32", f32, 0);
    send(32'h800002B7);
    chk("lui_imm64", m64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_fmt64", f64, 4);
    chk("lui_imm32", m32, 64'h8000_0000);
    send(32'h0000001B);
    chk("opimm32_ill64", l64, 0);
    chk("opimm32_fmt64", f64, 1);
    chk("opimm32_ill32", l32, 1);
    send(32'h300FD073);
    chk("csr_imm32", m32, 64'h1F);
    chk("csr_fmt32", f32, 6);
    chk("csr_imm64", m64, 64'h300);
    chk("csr_fmt64", f64, 1);
    cycle();

    // Skid fill under backpressure, then drain at full rate
    in_instr  = 32'hFFF00093;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 64'd0;
    cycle();
    chk("skid_ready_one", r32, 1);
    in_pc = 64'd4;
    cycle();
    chk("skid_ready_full", r32, 0);
    cycle();
    chk("skid_hold_pc", p32, 0);
    next_pc   = 64'd8;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", v32, 1);
      chk("drain_pc", p32, 64'(4 * i));
      in_valid = (next_pc <= 64'd12);
      in_pc    = next_pc;
      k        = (in_valid && r32) ? 1 : 0;
      cycle();
      if (k == 1) next_pc = next_pc + 64'd4;
    end
    in_valid = 1'b0;
    cycle();

    // Flush while full with a pending instruction
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 64'h100;
    cycle();
    in_pc = 64'h104;
    cycle();
    in_pc = 64'h108;
    flush = 1'b1;
    cycle();
    chk("flush_valid", v32, 0);
    chk("flush_ready", r32, 1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("flush_gone", v32, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 64'h40;
    cycle();
    in_pc = 64'h44;
    cycle();
    rst = 1'b1;
    #1;
    chk("arst_valid32", v32, 0);
    chk("arst_ready32", r32, 1);
    chk("arst_instr32", i32, 0);
    chk("arst_pc32", p32, 0);
    chk("arst_imm32", m32, 0);
    chk("arst_fmt32", f32, 0);
    chk("arst_ill32", l32, 0);
    chk("arst_valid64", v64, 0);
    chk("arst_imm64", m64, 0);
    q32.delete();
    q64.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic
    repeat (1500) begin
      k = $urandom_range(0, 15);
      r = $urandom;
      in_instr  = (k < 13) ? {r[31:7], ops[k]} : $urandom;
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
